ring_meas_sched: RTL and testbench

Measurement scheduler for the ring-oscillator grey-counter datapath. It walks the enabled ring channels in order. For each channel it clears that ring's grey counter and gates it on for a programmable window of reference clocks. It then synchronises and stabilises the stopped grey count, converts it to binary and presents it on a valid/ready result port. It sits between the ring/grey-counter array and the scan/LED readout logic, all in the i_clk domain.

---
 rtl/ring_meas_sched.sv | 181 ++++++++++++++++++
 tb/tb_ring_meas_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_meas_sched.sv
// rtl/ring_meas_sched.sv - ring-oscillator measurement scheduler (optional RING_SEQ_EN adds o_seq)
module ring_meas_sched #(
  parameter int pCHANNELS = 5,
  parameter int pCNT_W    = 10,
  parameter int pWIN_W    = 16,
  parameter int pSYNC     = 2,
  parameter int pRETRY    = 4
) (
  input  logic                                              i_clk,
  input  logic                                              i_rst_n,
  input  logic                                              i_start,
  input  logic                                              i_continuous,
  input  logic [pCHANNELS-1:0]                              i_chan_mask,
  input  logic [pWIN_W-1:0]                                 i_window,
  input  logic [pCHANNELS*pCNT_W-1:0]                       i_grey,
  output logic [pCHANNELS-1:0]                              o_ring_clr,
  output logic [pCHANNELS-1:0]                              o_ring_en,
  output logic                                              o_busy,
  output logic                                              o_valid,
  input  logic                                              i_ready,
  output logic [((pCHANNELS > 1) ? $clog2(pCHANNELS) : 1)-1:0] o_chan,
  output logic [pCNT_W-1:0]                                 o_count,
  output logic                                              o_unstable,
`ifdef RING_SEQ_EN
  output logic [7:0]                                        o_seq,
`endif
  output logic                                              o_done
);

  localparam int CH_W  = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1;
  localparam int RTR_W = (pRETRY > 1) ? $clog2(pRETRY) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_CLEAR, S_RUN, S_SETTLE, S_SAMPLE, S_PRESENT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [pCHANNELS-1:0] mask_q, measured_q, pending, onehot;
  logic [pWIN_W-1:0]    win_q, tmr_q, win_m1;
  logic [CH_W-1:0]      ch_q, pick_ch;
  logic                 pick_any;
  logic [pCNT_W-1:0]    sync_q [pSYNC];
  logic [pCNT_W-1:0]    grey_sel, sync_out, samp_q, bin_val, count_q;
  logic [RTR_W-1:0]     miss_q;
  logic                 sample_eq, sample_last, unstable_q;
`ifdef RING_SEQ_EN
  logic [7:0]           seq_q;
`endif

  assign onehot      = pCHANNELS'(1) << ch_q;
  assign grey_sel    = i_grey[int'(ch_q)*pCNT_W +: pCNT_W];
  assign sync_out    = sync_q[pSYNC-1];
  assign win_m1      = (win_q == '0) ? '0 : win_q - pWIN_W'(1);
  assign sample_eq   = (sync_out == samp_q);
  assign sample_last = (miss_q == RTR_W'(pRETRY - 1));

  // lowest-index channel still waiting in this pass
  always_comb begin
    pending  = mask_q & ~measured_q;
    pick_any = |pending;
    pick_ch  = '0;
    for (int k = pCHANNELS - 1; k >= 0; k--) begin
      if (pending[k]) pick_ch = CH_W'(k);
    end
  end

  // grey to binary: each binary bit is the parity of the grey bits at and above it
  always_comb begin
    bin_val = '0;
    for (int i = 0; i < pCNT_W; i++) begin
      bin_val[i] = ^(sync_out >> i);
    end
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next-state and state-decoded outputs
  always_comb begin
    state_d    = state_q;
    o_ring_clr = '0;
    o_ring_en  = '0;
    o_busy     = (state_q != S_IDLE);
    o_valid    = 1'b0;
    o_done     = 1'b0;
    case (state_q)
      S_IDLE:    if (i_start) state_d = S_PICK;
      S_PICK:    state_d = pick_any ? S_CLEAR : S_DONE;
      S_CLEAR: begin
        o_ring_clr = onehot;
        if (tmr_q == '0) state_d = S_RUN;
      end
      S_RUN: begin
        o_ring_en = onehot;
        if (tmr_q == '0) state_d = S_SETTLE;
      end
      S_SETTLE:  if (tmr_q == '0) state_d = S_SAMPLE;
      S_SAMPLE:  if (sample_eq || sample_last) state_d = S_PRESENT;
      S_PRESENT: begin
        o_valid = 1'b1;
        if (i_ready) state_d = S_PICK;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = i_continuous ? S_PICK : S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // pass bookkeeping, phase timer, grey synchroniser and result capture
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mask_q     <= '0;
      measured_q <= '0;
      win_q      <= '0;
      tmr_q      <= '0;
      ch_q       <= '0;
      miss_q     <= '0;
      samp_q     <= '0;
      count_q    <= '0;
      unstable_q <= 1'b0;
      for (int i = 0; i < pSYNC; i++) sync_q[i] <= '0;
`ifdef RING_SEQ_EN
      seq_q      <= '0;
`endif
    end else begin
      sync_q[0] <= grey_sel;
      for (int i = 1; i < pSYNC; i++) sync_q[i] <= sync_q[i-1];
      samp_q <= sync_out;
      case (state_q)
        S_IDLE: if (i_start) begin
          mask_q     <= i_chan_mask;
          win_q      <= i_window;
          measured_q <= '0;
        end
        S_PICK: begin
          ch_q  <= pick_ch;
          tmr_q <= pWIN_W'(1);
        end
        S_CLEAR:  tmr_q <= (tmr_q == '0) ? win_m1 : tmr_q - pWIN_W'(1);
        S_RUN: begin
          tmr_q  <= (tmr_q == '0) ? pWIN_W'(pSYNC + 1) : tmr_q - pWIN_W'(1);
          miss_q <= '0;
        end
        S_SETTLE: if (tmr_q != '0) tmr_q <= tmr_q - pWIN_W'(1);
        S_SAMPLE: begin
          if (sample_eq || sample_last) begin
            count_q    <= bin_val;
            unstable_q <= !sample_eq;
          end else begin
            miss_q <= miss_q + RTR_W'(1);
          end
        end
        S_PRESENT: if (i_ready) begin
          measured_q <= measured_q | onehot;
`ifdef RING_SEQ_EN
          seq_q      <= seq_q + 8'd1;
`endif
        end
        S_DONE: if (i_continuous) begin
          mask_q     <= i_chan_mask;
          win_q      <= i_window;
          measured_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_chan     = ch_q;
  assign o_count    = count_q;
  assign o_unstable = unstable_q;
`ifdef RING_SEQ_EN
  assign o_seq      = seq_q;
`endif

endmodule

// File: tb/tb_ring_meas_sched.sv
// tb/tb_ring_meas_sched.sv - randomized self-checking bench for ring_meas_sched
module tb_ring_meas_sched;
  localparam int NCH = 5, CW = 10, WW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            i_rst_n = 1'b0, i_start = 1'b0, i_continuous = 1'b0, i_ready = 1'b1;
  logic [NCH-1:0]  i_chan_mask = '0;
  logic [WW-1:0]   i_window = '0;
  logic [NCH*CW-1:0] grey_bus;
  logic [NCH-1:0]  o_ring_clr, o_ring_en;
  logic            o_busy, o_valid, o_unstable, o_done;
  logic [2:0]      o_chan;
  logic [CW-1:0]   o_count;
`ifdef RING_SEQ_EN
  logic [7:0]      o_seq;
  int              res_seq[$];
`endif

  ring_meas_sched dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_continuous(i_continuous),
    .i_chan_mask(i_chan_mask), .i_window(i_window), .i_grey(grey_bus),
    .o_ring_clr(o_ring_clr), .o_ring_en(o_ring_en), .o_busy(o_busy), .o_valid(o_valid),
    .i_ready(i_ready), .o_chan(o_chan), .o_count(o_count), .o_unstable(o_unstable),
`ifdef RING_SEQ_EN
    .o_seq(o_seq),
`endif
    .o_done(o_done)
  );

  int checks = 0;
  int errors = 0;

  // ring counter array model: clear wins, gate counts one per reference clock
  logic [CW-1:0] ring_cnt [NCH];
  logic          tog = 1'b0;
  int            grey_mode = 0;
  logic [CW-1:0] static_val = '0;
  logic [CW-1:0] g_tmp;
  always @(posedge clk) begin
    tog <= ~tog;
    for (int k = 0; k < NCH; k++) begin
      if (o_ring_clr[k])     ring_cnt[k] <= '0;
      else if (o_ring_en[k]) ring_cnt[k] <= ring_cnt[k] + 1'b1;
    end
  end
  always_comb begin
    grey_bus = '0;
    g_tmp    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grey_mode == 0)      g_tmp = ring_cnt[k] ^ (ring_cnt[k] >> 1);
      else if (grey_mode == 1) g_tmp = static_val;
      else                     g_tmp = static_val ^ {CW{tog}};
      grey_bus[k*CW +: CW] = g_tmp;
    end
  end

  // observation: accepted results, gate/clear pulse lengths, done pulses, overlap
  int res_chan[$], res_cnt[$], res_unst[$], en_runs[$], clr_runs[$];
  int en_run = 0, clr_run = 0, done_cnt = 0, overlap = 0;
  always @(negedge clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      res_chan.push_back(int'(o_chan));
      res_cnt.push_back(int'(o_count));
      res_unst.push_back(int'(o_unstable));
`ifdef RING_SEQ_EN
      res_seq.push_back(int'(o_seq));
`endif
    end
    if (o_done) done_cnt++;
    if ((|o_ring_en) && (|o_ring_clr)) overlap++;
    if ($countones(o_ring_en) > 1 || $countones(o_ring_clr) > 1) overlap++;
    if (|o_ring_en) en_run++;
    else if (en_run != 0) begin en_runs.push_back(en_run); en_run = 0; end
    if (|o_ring_clr) clr_run++;
    else if (clr_run != 0) begin clr_runs.push_back(clr_run); clr_run = 0; end
  end

  // reference model: channels in ascending mask order, count = effective window mod 2^CW
  int exp_chan[$];
  int exp_count;
  function automatic void build_expect(logic [NCH-1:0] m, logic [WW-1:0] w);
    exp_chan.delete();
    for (int k = 0; k < NCH; k++) if (m[k]) exp_chan.push_back(k);
    exp_count = ((w == 0) ? 1 : int'(w)) % (1 << CW);
  endfunction

  // grey decode by exhaustive search: the n whose grey code equals g
  function automatic int grey_inv(logic [CW-1:0] g);
    for (int n = 0; n < (1 << CW); n++) if ((n ^ (n >> 1)) == int'(g)) return n;
    return -1;
  endfunction

  bit rand_ready = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    res_chan.delete(); res_cnt.delete(); res_unst.delete(); en_runs.delete(); clr_runs.delete();
`ifdef RING_SEQ_EN
    res_seq.delete();
`endif
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_start = 1'b0; i_continuous = 1'b0; i_ready = 1'b1;
    repeat (3) tick();
    i_rst_n = 1'b1;
    tick();
    clear_obs();
  endtask

  task automatic start_pass(input logic [NCH-1:0] m, input logic [WW-1:0] w);
    i_chan_mask = m; i_window = w; i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    int n = 0;
    timed_out = 0;
    forever begin
      @(negedge clk);
      if (!o_busy) break;
      n++;
      if (n >= budget) begin timed_out = 1; break; end
      @(posedge clk); #1;
      if (rand_ready) i_ready = ($urandom_range(0, 2) != 0);
    end
    i_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", o_busy); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", o_valid); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", o_done); end
    checks++; if ({o_ring_en, o_ring_clr} !== '0) begin errors++; $display("FAIL reset_ring got %b want 0", {o_ring_en, o_ring_clr}); end
    checks++; if ({o_chan, o_count, o_unstable} !== '0) begin errors++; $display("FAIL reset_result got %h want 0", {o_chan, o_count, o_unstable}); end
`ifdef RING_SEQ_EN
    checks++; if (o_seq !== 8'd0) begin errors++; $display("FAIL reset_seq got %0d want 0", o_seq); end
`endif
  endtask

  task automatic test_basic();
    bit to; int d0, ov0;
    grey_mode = 0; d0 = done_cnt; ov0 = overlap;
    build_expect(5'b00101, 16'd10);
    start_pass(5'b00101, 16'd10);
    wait_idle(500, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout busy=%0b want 0", o_busy); end
    checks++; if (res_chan.size() != exp_chan.size()) begin errors++; $display("FAIL basic_nres got %0d want %0d", res_chan.size(), exp_chan.size()); end
    for (int i = 0; i < exp_chan.size() && i < res_chan.size(); i++) begin
      checks++; if (res_chan[i] != exp_chan[i]) begin errors++; $display("FAIL basic_chan%0d got %0d want %0d", i, res_chan[i], exp_chan[i]); end
      checks++; if (res_cnt[i] != exp_count || res_unst[i] != 0) begin errors++; $display("FAIL basic_count%0d got %0d/%0d want %0d/0", i, res_cnt[i], res_unst[i], exp_count); end
      checks++; if (clr_runs.size() <= i || clr_runs[i] != 2) begin errors++; $display("FAIL basic_clr_len%0d got %0d want 2", i, (clr_runs.size() > i) ? clr_runs[i] : -1); end
      checks++; if (en_runs.size() <= i || en_runs[i] != 10) begin errors++; $display("FAIL basic_en_len%0d got %0d want 10", i, (en_runs.size() > i) ? en_runs[i] : -1); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done got %0d want 1", done_cnt - d0); end
    checks++; if (overlap != ov0) begin errors++; $display("FAIL basic_overlap got %0d want 0", overlap - ov0); end
    clear_obs();
  endtask

  task automatic test_empty_mask();
    start_pass(5'b00000, 16'd5);
    @(negedge clk);
    checks++; if ({o_busy, o_done} !== 2'b10) begin errors++; $display("FAIL empty_pick got %b want 10", {o_busy, o_done}); end
    @(negedge clk);
    checks++; if ({o_busy, o_done} !== 2'b11) begin errors++; $display("FAIL empty_done got %b want 11", {o_busy, o_done}); end
    @(negedge clk);
    checks++; if ({o_busy, o_done, o_valid} !== 3'b000) begin errors++; $display("FAIL empty_idle got %b want 000", {o_busy, o_done, o_valid}); end
    checks++; if (res_chan.size() != 0 || en_runs.size() != 0) begin errors++; $display("FAIL empty_activity got %0d/%0d want 0/0", res_chan.size(), en_runs.size()); end
    clear_obs();
  endtask

  task automatic test_window_zero();
    bit to;
    grey_mode = 0;
    start_pass(5'b00010, 16'd0);
    wait_idle(200, to);
    checks++; if (to || en_runs.size() != 1 || en_runs[0] != 1) begin errors++; $display("FAIL win0_en_len got %0d want 1", (en_runs.size() > 0) ? en_runs[0] : -1); end
    checks++; if (res_cnt.size() != 1 || res_cnt[0] != 1 || res_chan[0] != 1) begin errors++; $display("FAIL win0_result got n=%0d want chan 1 count 1", res_cnt.size()); end
    clear_obs();
  endtask

  task automatic test_static_grey();
    bit to; int want;
    grey_mode = 1; static_val = 10'b1100000000; want = grey_inv(static_val);
    start_pass(5'b00001, 16'd3);
    wait_idle(200, to);
    checks++; if (to || res_cnt.size() != 1 || res_cnt[0] != want || res_unst[0] != 0) begin errors++; $display("FAIL static_count got %0d want %0d", (res_cnt.size() > 0) ? res_cnt[0] : -1, want); end
    grey_mode = 0;
    clear_obs();
  endtask

  task automatic test_unstable();
    bit to; int a, b;
    grey_mode = 2; static_val = CW'($urandom); a = grey_inv(static_val); b = grey_inv(~static_val);
    start_pass(5'b00100, 16'd4);
    wait_idle(200, to);
    checks++; if (to || res_unst.size() != 1 || res_unst[0] != 1 || res_chan[0] != 2) begin errors++; $display("FAIL unstable_flag got n=%0d want one result chan 2 unstable 1", res_unst.size()); end
    checks++; if (res_cnt.size() != 1 || (res_cnt[0] != a && res_cnt[0] != b)) begin errors++; $display("FAIL unstable_count got %0d want %0d or %0d", (res_cnt.size() > 0) ? res_cnt[0] : -1, a, b); end
    grey_mode = 0;
    clear_obs();
  endtask

  task automatic test_backpressure();
    bit to; int n, bad, hc, hn;
    grey_mode = 0; i_ready = 1'b0;
    start_pass(5'b00011, 16'd7);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_valid && n < 300);
    checks++; if (!o_valid) begin errors++; $display("FAIL bp_valid_timeout got 0 want 1"); end
    hc = int'(o_chan); hn = int'(o_count); bad = 0;
    checks++; if (hc != 0 || hn != 7) begin errors++; $display("FAIL bp_first got chan %0d count %0d want 0/7", hc, hn); end
    repeat (50) begin
      @(negedge clk);
      if (o_valid !== 1'b1 || int'(o_chan) != hc || int'(o_count) != hn || (|o_ring_en) || (|o_ring_clr)) bad++;
    end
    checks++; if (bad != 0 || en_runs.size() != 1) begin errors++; $display("FAIL bp_hold got %0d bad cycles, %0d gates want 0/1", bad, en_runs.size()); end
    @(posedge clk); #1;
    i_ready = 1'b1;
    wait_idle(300, to);
    checks++; if (to || res_chan.size() != 2 || res_chan[1] != 1 || res_cnt[1] != 7) begin errors++; $display("FAIL bp_second got n=%0d want chan 1 count 7", res_chan.size()); end
    clear_obs();
  endtask

  task automatic test_reset_mid_run();
    bit to; int n = 0;
    start_pass(5'b11111, 16'd20);
    do begin @(negedge clk); n++; end while (!(|o_ring_en) && n < 100);
    i_rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if ({o_ring_en, o_busy, o_valid} !== '0) begin errors++; $display("FAIL rst_run got en=%b busy=%0b valid=%0b want 0", o_ring_en, o_busy, o_valid); end
    i_rst_n = 1'b1;
    tick();
    clear_obs();
    build_expect(5'b10110, 16'd4);
    start_pass(5'b10110, 16'd4);
    wait_idle(500, to);
    checks++; if (to || res_chan.size() != exp_chan.size()) begin errors++; $display("FAIL rst_restart_n got %0d want %0d", res_chan.size(), exp_chan.size()); end
    for (int i = 0; i < exp_chan.size() && i < res_chan.size(); i++) begin
      checks++; if (res_chan[i] != exp_chan[i] || res_cnt[i] != exp_count) begin errors++; $display("FAIL rst_restart%0d got %0d/%0d want %0d/%0d", i, res_chan[i], res_cnt[i], exp_chan[i], exp_count); end
    end
    clear_obs();
  endtask

  task automatic test_continuous();
    bit to; int n = 0, d0;
    do_reset();
    d0 = done_cnt;
    i_continuous = 1'b1;
    start_pass(5'b11111, 16'd5);
    while (res_chan.size() < 6 && n < 2000) begin @(negedge clk); n++; end
    i_continuous = 1'b0;
    wait_idle(2000, to);
    checks++; if (to || res_chan.size() != 10) begin errors++; $display("FAIL cont_nres got %0d want 10", res_chan.size()); end
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL cont_done got %0d want 2", done_cnt - d0); end
    for (int i = 0; i < res_chan.size() && i < 10; i++) begin
      checks++; if (res_chan[i] != i % NCH || res_cnt[i] != 5) begin errors++; $display("FAIL cont_res%0d got %0d/%0d want %0d/5", i, res_chan[i], res_cnt[i], i % NCH); end
`ifdef RING_SEQ_EN
      checks++; if (res_seq[i] != i) begin errors++; $display("FAIL cont_seq%0d got %0d want %0d", i, res_seq[i], i); end
`endif
    end
    clear_obs();
  endtask

  task automatic test_random();
    bit to; logic [NCH-1:0] m; logic [WW-1:0] w;
    grey_mode = 0; rand_ready = 1;
    for (int it = 0; it < 8; it++) begin
      m = NCH'($urandom); w = WW'($urandom_range(0, 12));
      build_expect(m, w);
      start_pass(m, w);
      wait_idle(1500, to);
      checks++; if (to || res_chan.size() != exp_chan.size()) begin errors++; $display("FAIL rand%0d_n mask %b got %0d want %0d", it, m, res_chan.size(), exp_chan.size()); end
      for (int i = 0; i < exp_chan.size() && i < res_chan.size(); i++) begin
        checks++; if (res_chan[i] != exp_chan[i] || res_cnt[i] != exp_count || res_unst[i] != 0) begin errors++; $display("FAIL rand%0d_res%0d got %0d/%0d want %0d/%0d", it, i, res_chan[i], res_cnt[i], exp_chan[i], exp_count); end
      end
      clear_obs();
    end
    rand_ready = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_mask();
    test_window_zero();
    test_static_grey();
    test_unstable();
    test_backpressure();
    test_reset_mid_run();
    test_continuous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end
endmodule
